// File: rtl/rr_stream_mux.sv
// N-way valid/ready stream merger with a one-deep registered output stage.
// The source is picked by an explicit select (MODE=0) or by round-robin arbitration (MODE=1).
module rr_stream_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int MODE  = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_grant,
    input  logic               out_ready
);

    logic             load_en;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [SELW:0]    cand;
    logic [SELW-1:0]  ptr;
    logic [WIDTH-1:0] grant_data;

    assign load_en = ~out_valid | out_ready;

    always_comb begin : grant_select
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (MODE == 0) begin
            // Matching sel against each real channel also rejects sel >= N.
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                cand = {1'b0, ptr} + (SELW+1)'(j);
                if (cand >= (SELW+1)'(N)) cand = cand - (SELW+1)'(N);
                if (!grant_vld && in_valid[cand[SELW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[SELW-1:0];
                end
            end
        end
    end

    always_comb begin : data_select
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Reset is gated in so no channel sees an accept while the block is held in reset.
    always_comb begin : ready_decode
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst && load_en && grant_vld && (grant_idx == SELW'(i));
        end
    end

    // NOTE: non-blocking assignments make every register update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data  <= grant_data;
                out_grant <= grant_idx;
                if (MODE != 0) begin
                    ptr <= (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: four configurations (N=8/5, MODE=1/0) share one stimulus;
// each lane has a reference model feeding a scoreboard queue and an independent monitor.
module tb_rr_stream_mux;

    localparam int W     = 32;
    localparam int NMAX  = 8;
    localparam int LANES = 4;

    typedef struct packed {
        logic [2:0]   g;
        logic [W-1:0] d;
    } word_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [NMAX-1:0]             in_valid = '0;
    logic [NMAX*W-1:0]           in_data = '0;
    logic [2:0]                  sel = '0;
    logic                        out_ready = 1'b0;
    logic [LANES-1:0]            o_valid;
    logic [LANES-1:0][W-1:0]     o_data;
    logic [LANES-1:0][2:0]       o_grant;
    logic [LANES-1:0][NMAX-1:0]  o_rdy;

    int n_checks = 0;
    int n_fail   = 0;
    int act_lane = -1;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Lanes: 0 = N8 round-robin, 1 = N8 select, 2 = N5 select, 3 = N5 round-robin.
    for (genvar L = 0; L < LANES; L++) begin : lane
        localparam int NL = (L < 2) ? 8 : 5;
        localparam int ML = (L == 0 || L == 3) ? 1 : 0;

        logic [NL-1:0] rdy;

        rr_stream_mux #(.WIDTH(W), .N(NL), .MODE(ML)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[NL-1:0]),
            .in_data   (in_data[NL*W-1:0]),
            .in_ready  (rdy),
            .sel       (sel),
            .out_valid (o_valid[L]),
            .out_data  (o_data[L]),
            .out_grant (o_grant[L]),
            .out_ready (out_ready)
        );

        assign o_rdy[L] = NMAX'(rdy);

        word_t             sb[$];
        bit                m_valid = 1'b0;
        int                m_ptr   = 0;
        word_t             m_cur   = '0;
        logic [NMAX-1:0]   p_valid = '0;
        logic [NMAX-1:0]   p_rdy   = '0;
        logic [NMAX*W-1:0] p_data  = '0;
        logic              p_rst   = 1'b0;

        // Reference model: predicts the coming clock edge from the spec's rules.
        always @(negedge clk) begin : model
            int              g;
            bit              load;
            logic [NMAX-1:0] exp_rdy;
            string           tag;
            tag = $sformatf("lane%0d", L);
            check({tag, " out_valid"}, 64'(o_valid[L]), 64'(m_valid));
            if (!m_valid) begin
                check({tag, " idle out_data"}, 64'(o_data[L]), 64'(m_cur.d));
                check({tag, " idle out_grant"}, 64'(o_grant[L]), 64'(m_cur.g));
            end
            if (L == act_lane && rst && p_rst) begin
                for (int i = 0; i < NL; i++) begin
                    if (p_valid[i] && !p_rdy[i])
                        check({tag, " upstream hold"}, {in_valid[i], in_data[i*W +: W]},
                              {1'b1, p_data[i*W +: W]});
                end
            end
            g = -1;
            if (ML == 0) begin
                if (int'(sel) < NL && in_valid[sel]) g = int'(sel);
            end else begin
                for (int k = 0; k < NL; k++)
                    if (g < 0 && in_valid[(m_ptr + k) % NL]) g = (m_ptr + k) % NL;
            end
            load    = !m_valid || out_ready;
            exp_rdy = '0;
            if (rst && load && g >= 0) exp_rdy[g] = 1'b1;
            check({tag, " in_ready"}, 64'(o_rdy[L]), 64'(exp_rdy));
            p_valid = in_valid;
            p_rdy   = o_rdy[L];
            p_data  = in_data;
            p_rst   = rst;
            if (!rst) begin
                m_valid = 1'b0;
                m_ptr   = 0;
                m_cur   = '0;
                sb.delete();
            end else if (load) begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_cur = {3'(g), in_data[g*W +: W]};
                    sb.push_back(m_cur);
                    if (ML == 1) m_ptr = (g + 1) % NL;
                end
            end
        end

        // Monitor: each word leaving on a downstream handshake must be the next one queued.
        always @(negedge clk) begin : monitor
            word_t w;
            if (rst && o_valid[L] && out_ready) begin
                if (sb.size() == 0) begin
                    check($sformatf("lane%0d word without accept", L), 64'(o_valid[L]), 64'd0);
                end else begin
                    w = sb.pop_front();
                    check($sformatf("lane%0d sb grant", L), 64'(o_grant[L]), 64'(w.g));
                    check($sformatf("lane%0d sb data", L), 64'(o_data[L]), 64'(w.d));
                end
            end
        end
    end

    task automatic rand_cycle(input int l);
        logic [NMAX-1:0] acc;
        @(negedge clk);
        acc = rst ? (in_valid & o_rdy[l]) : '1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NMAX; i++) begin
            if (!in_valid[i] || acc[i]) begin
                in_valid[i]       = ($urandom_range(99) < 60);
                in_data[i*W +: W] = $urandom;
            end
        end
        sel       = 3'($urandom_range(7));
        out_ready = ($urandom_range(99) < 70);
        rst       = ($urandom_range(99) >= 2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sp[3];
        exp_sp = '{5, 2, 5};

        rst       = 1'b0;
        out_ready = 1'b1;
        sel       = 3'd0;
        in_valid  = '1;
        for (int i = 0; i < NMAX; i++) in_data[i*W +: W] = 32'hA000_0000 + i;

        repeat (3) begin
            cyc();
            for (int l = 0; l < LANES; l++) begin
                check($sformatf("reset lane%0d out_valid", l), 64'(o_valid[l]), 64'd0);
                check($sformatf("reset lane%0d out_data", l), 64'(o_data[l]), 64'd0);
                check($sformatf("reset lane%0d out_grant", l), 64'(o_grant[l]), 64'd0);
                check($sformatf("reset lane%0d in_ready", l), 64'(o_rdy[l]), 64'd0);
            end
        end

        rst = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            cyc();
            check("sweep n8 out_valid", 64'(o_valid[0]), 64'd1);
            check("sweep n8 grant", 64'(o_grant[0]), 64'(k % 8));
            check("sweep n8 data", 64'(o_data[0]), 64'(32'hA000_0000 + (k % 8)));
            check("sweep n5 grant", 64'(o_grant[3]), 64'(k % 5));
            check("sweep n5 data", 64'(o_data[3]), 64'(32'hA000_0000 + (k % 5)));
        end

        in_valid = 8'b0000_0100;
        cyc();
        check("sparse setup grant", 64'(o_grant[0]), 64'd2);
        in_valid = 8'b0010_0100;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("sparse grant", 64'(o_grant[0]), 64'(exp_sp[k]));
            check("sparse data", 64'(o_data[0]), 64'(32'hA000_0000 + exp_sp[k]));
        end

        in_valid             = 8'b0000_0010;
        in_data[1*W +: W]    = 32'hDEAD_BEEF;
        cyc();
        check("bp word data", 64'(o_data[0]), 64'h0000_0000_DEAD_BEEF);
        check("bp word grant", 64'(o_grant[0]), 64'd1);
        out_ready = 1'b0;
        in_valid  = 8'b0000_1110;
        repeat (4) begin
            cyc();
            check("bp held valid", 64'(o_valid[0]), 64'd1);
            check("bp held data", 64'(o_data[0]), 64'h0000_0000_DEAD_BEEF);
            check("bp held grant", 64'(o_grant[0]), 64'd1);
            check("bp in_ready", 64'(o_rdy[0]), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(o_rdy[0]), 64'h04);
        cyc();
        check("bp release grant", 64'(o_grant[0]), 64'd2);
        check("bp release data", 64'(o_data[0]), 64'(32'hA000_0002));

        sel               = 3'd6;
        in_data[6*W +: W] = 32'h1234_5678;
        in_valid          = 8'hEF;
        cyc();
        check("sel6 data", 64'(o_data[1]), 64'h1234_5678);
        check("sel6 grant", 64'(o_grant[1]), 64'd6);
        check("sel6 valid", 64'(o_valid[1]), 64'd1);
        sel = 3'd4;
        #1;
        check("sel4 invalid in_ready", 64'(o_rdy[1]), 64'd0);
        cyc();
        check("sel4 out_valid", 64'(o_valid[1]), 64'd0);
        check("sel4 data held", 64'(o_data[1]), 64'h1234_5678);
        check("sel4 grant held", 64'(o_grant[1]), 64'd6);

        sel      = 3'd3;
        in_valid = 8'hFF;
        cyc();
        check("n5 sel3 grant", 64'(o_grant[2]), 64'd3);
        check("n5 sel3 valid", 64'(o_valid[2]), 64'd1);
        sel = 3'd7;
        #1;
        check("n5 sel7 in_ready", 64'(o_rdy[2]), 64'd0);
        cyc();
        check("n5 sel7 out_valid", 64'(o_valid[2]), 64'd0);

        sel = 3'd0;
        cyc();
        out_ready = 1'b0;
        cyc();
        check("midrst held valid", 64'(o_valid[3]), 64'd1);
        rst = 1'b0;
        cyc();
        check("midrst out_valid", 64'(o_valid[3]), 64'd0);
        check("midrst out_data", 64'(o_data[3]), 64'd0);
        check("midrst out_grant", 64'(o_grant[3]), 64'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        cyc();
        check("post rst n5 grant", 64'(o_grant[3]), 64'd0);
        check("post rst n5 data", 64'(o_data[3]), 64'(32'hA000_0000));
        check("post rst n8 grant", 64'(o_grant[0]), 64'd0);

        for (int l = 0; l < LANES; l++) begin
            act_lane = l;
            repeat (400) rand_cycle(l);
        end

        act_lane  = -1;
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
